// File: rtl/data_unpack_pkg.sv
// Shared types and sizing helpers for the streaming word-to-packet unpacker.
package data_unpack_pkg;

  // Frame state: RUN accepts words and emits only full packets.
  // DRAIN flushes the rest of a frame, padding the final packet with zeros.
  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } unpack_state_t;

  // Accumulator width: one whole word plus the largest residue that can
  // still be waiting, which is PKT_W-1 bits.
  function automatic int acc_width(input int word_w, input int pkt_w);
    return word_w + pkt_w - 32'sd1;
  endfunction

endpackage

// File: rtl/data_unpack_acc.sv
// Left-aligned bit accumulator with a packet-sized pop and an offset word insert.
// Valid bits occupy acc_q[ACC_W-1 -: fill_q], and every bit below them is zero.
// Because of that, the head packet of a short residue is already zero-padded.
module data_unpack_acc
  import data_unpack_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int PKT_W  = 7,
  parameter int ACC_W  = acc_width(WORD_W, PKT_W),
  parameter int FILL_W = $clog2(ACC_W + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [WORD_W-1:0] in_data,
  output logic [PKT_W-1:0]  head_q,
  output logic [FILL_W-1:0] fill_q
);

  localparam logic [FILL_W-1:0] PKT_F  = FILL_W'(PKT_W);
  localparam logic [FILL_W-1:0] WORD_F = FILL_W'(WORD_W);
  localparam logic [ACC_W-1:0]  ONES   = {ACC_W{1'b1}};

  logic [ACC_W-1:0]  acc_q;
  logic [ACC_W-1:0]  acc_d;
  logic [FILL_W-1:0] fill_d;
  logic [ACC_W-1:0]  acc_pop_s;
  logic [FILL_W-1:0] fill_pop_s;
  logic [ACC_W-1:0]  word_top_s;
  logic [ACC_W-1:0]  word_ins_s;
  logic [ACC_W-1:0]  keep_s;

  // Pop: drop the head packet. A short (padded) head empties the accumulator.
  always_comb begin
    acc_pop_s  = acc_q;
    fill_pop_s = fill_q;
    if (pop) begin
      acc_pop_s = acc_q << PKT_W;
      if (fill_q >= PKT_F) begin
        fill_pop_s = fill_q - PKT_F;
      end else begin
        fill_pop_s = {FILL_W{1'b0}};
      end
    end else begin
      acc_pop_s  = acc_q;
      fill_pop_s = fill_q;
    end
  end

  // Push: place the new word directly below the bits that survive the pop.
  // The handshake only allows a push with at most PKT_W-1 surviving bits,
  // so the shifted word always fits.
  always_comb begin
    word_top_s = ACC_W'(in_data) << (ACC_W - WORD_W);
    word_ins_s = word_top_s >> fill_pop_s;
    keep_s     = ~(ONES >> fill_pop_s);
    acc_d      = acc_pop_s;
    fill_d     = fill_pop_s;
    if (push) begin
      acc_d  = (acc_pop_s & keep_s) | word_ins_s;
      fill_d = fill_pop_s + WORD_F;
    end else begin
      acc_d  = acc_pop_s;
      fill_d = fill_pop_s;
    end
  end

  // Accumulator and fill registers. An asynchronous reset drops all buffered bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q  <= {ACC_W{1'b0}};
      fill_q <= {FILL_W{1'b0}};
    end else begin
      acc_q  <= acc_d;
      fill_q <= fill_d;
    end
  end

  // The head packet is always the top PKT_W bits.
  assign head_q = acc_q[ACC_W-1 -: PKT_W];

endmodule

// File: rtl/data_unpack_stream.sv
// Streaming unpacker: MSB-first WORD_W-bit words in, PKT_W-bit packets out,
// with valid/ready on both sides and in_last/out_last frame termination.
module data_unpack_stream
  import data_unpack_pkg::*;
#(
  parameter  int WORD_W = 32,
  parameter  int PKT_W  = 7,
  localparam int ACC_W  = acc_width(WORD_W, PKT_W),
  localparam int FILL_W = $clog2(ACC_W + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [PKT_W-1:0]  out_data,
  output logic              out_valid,
  output logic              out_last,
  input  logic              out_ready,
  output logic [FILL_W-1:0] fill
);

  if (PKT_W < 1 || PKT_W > WORD_W || WORD_W > 64) begin : g_bad_params
    $error("data_unpack_stream: need 1 <= PKT_W <= WORD_W <= 64");
  end

  localparam logic [31:0] PKT_L  = 32'(PKT_W);
  localparam logic [31:0] PKT2_L = 32'(2 * PKT_W);

  unpack_state_t     state_q;
  unpack_state_t     state_d;
  logic [FILL_W-1:0] fill_q;
  logic [PKT_W-1:0]  head_q;
  logic [31:0]       fill_w_s;
  logic              in_ready_s;
  logic              out_valid_s;
  logic              out_last_s;
  logic              push_s;
  logic              pop_s;

  assign fill_w_s = 32'(fill_q);

  // Handshake outputs. in_ready depends combinationally on out_ready so that a
  // word can be accepted in the same cycle that the pop frees room for it.
  always_comb begin
    in_ready_s  = 1'b0;
    out_valid_s = 1'b0;
    out_last_s  = 1'b0;
    case (state_q)
      RUN: begin
        out_valid_s = (fill_w_s >= PKT_L);
        out_last_s  = 1'b0;
        if (rst) begin
          in_ready_s = 1'b0;
        end else begin
          in_ready_s = (fill_w_s < PKT_L) || ((fill_w_s < PKT2_L) && out_ready);
        end
      end
      DRAIN: begin
        in_ready_s  = 1'b0;
        out_valid_s = (fill_w_s != 32'd0);
        out_last_s  = (fill_w_s != 32'd0) && (fill_w_s <= PKT_L);
      end
      default: begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
        out_last_s  = 1'b0;
      end
    endcase
  end

  assign push_s = in_valid && in_ready_s;
  assign pop_s  = out_valid_s && out_ready;

  // Next frame state: a last word starts the drain, and the last packet ends it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (push_s && in_last) begin
          state_d = DRAIN;
        end else begin
          state_d = RUN;
        end
      end
      DRAIN: begin
        if (pop_s && out_last_s) begin
          state_d = RUN;
        end else begin
          state_d = DRAIN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Frame state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  data_unpack_acc #(
    .WORD_W (WORD_W),
    .PKT_W  (PKT_W),
    .ACC_W  (ACC_W),
    .FILL_W (FILL_W)
  ) u_acc (
    .clk     (clk),
    .rst     (rst),
    .push    (push_s),
    .pop     (pop_s),
    .in_data (in_data),
    .head_q  (head_q),
    .fill_q  (fill_q)
  );

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_s;
  assign out_last  = out_last_s;
  assign out_data  = head_q;
  assign fill      = fill_q;

endmodule

// File: tb/tb_data_unpack_stream.sv
// Bench for data_unpack_stream: four parameterisations share one stimulus path
// and one bit-queue scoreboard. Directed literals pin the scoreboard.
module tb_data_unpack_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  int          sel = 0;
  logic [63:0] in_data_g = 64'd0;
  logic        in_valid_g = 1'b0;
  logic        in_last_g = 1'b0;
  logic        dir_rdy = 1'b0;
  logic        rand_mode = 1'b0;
  logic        rnd_rdy = 1'b0;

  int WW   [4] = '{32, 16, 8, 64};
  int PW   [4] = '{7, 16, 3, 1};
  int ACCW [4] = '{38, 31, 10, 64};

  logic        iv_s [4];
  logic        or_s [4];
  logic        ir_a [4];
  logic        ov_a [4];
  logic        ol_a [4];
  logic [15:0] od_a [4];
  logic [7:0]  fl_a [4];

  logic [6:0]  od0; logic [5:0] f0;
  logic [15:0] od1; logic [4:0] f1;
  logic [2:0]  od2; logic [3:0] f2;
  logic [0:0]  od3; logic [6:0] f3;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      iv_s[i] = (sel == i) && in_valid_g;
      or_s[i] = (sel == i) && (rand_mode ? rnd_rdy : dir_rdy);
    end
  end

  data_unpack_stream #(.WORD_W(32), .PKT_W(7)) u0 (
    .clk(clk), .rst(rst), .in_data(in_data_g[31:0]), .in_valid(iv_s[0]), .in_last(in_last_g),
    .in_ready(ir_a[0]), .out_data(od0), .out_valid(ov_a[0]), .out_last(ol_a[0]),
    .out_ready(or_s[0]), .fill(f0));
  data_unpack_stream #(.WORD_W(16), .PKT_W(16)) u1 (
    .clk(clk), .rst(rst), .in_data(in_data_g[15:0]), .in_valid(iv_s[1]), .in_last(in_last_g),
    .in_ready(ir_a[1]), .out_data(od1), .out_valid(ov_a[1]), .out_last(ol_a[1]),
    .out_ready(or_s[1]), .fill(f1));
  data_unpack_stream #(.WORD_W(8), .PKT_W(3)) u2 (
    .clk(clk), .rst(rst), .in_data(in_data_g[7:0]), .in_valid(iv_s[2]), .in_last(in_last_g),
    .in_ready(ir_a[2]), .out_data(od2), .out_valid(ov_a[2]), .out_last(ol_a[2]),
    .out_ready(or_s[2]), .fill(f2));
  data_unpack_stream #(.WORD_W(64), .PKT_W(1)) u3 (
    .clk(clk), .rst(rst), .in_data(in_data_g), .in_valid(iv_s[3]), .in_last(in_last_g),
    .in_ready(ir_a[3]), .out_data(od3), .out_valid(ov_a[3]), .out_last(ol_a[3]),
    .out_ready(or_s[3]), .fill(f3));

  assign od_a[0] = 16'(od0); assign fl_a[0] = 8'(f0);
  assign od_a[1] = od1;      assign fl_a[1] = 8'(f1);
  assign od_a[2] = 16'(od2); assign fl_a[2] = 8'(f2);
  assign od_a[3] = 16'(od3); assign fl_a[3] = 8'(f3);

  // Random backpressure source, about 30 percent ready.
  always @(posedge clk) begin
    #1;
    rnd_rdy = ($urandom_range(0, 9) < 3);
  end

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: the frame is just a bit queue cut into PKT_W chunks.
  bit          bitq [$];
  logic [16:0] exp_q [$];   // {last, data}
  logic [16:0] got_q [$];   // every packet the DUT handed over
  logic        held_v = 1'b0;
  logic [15:0] held_d = 16'd0;
  logic        held_l = 1'b0;

  task automatic model_push(input logic [63:0] d, input logic l, input int s);
    logic [15:0] p;
    int n;
    for (int i = WW[s] - 1; i >= 0; i--) bitq.push_back(d[i]);
    while (bitq.size() >= PW[s]) begin
      p = 16'd0;
      for (int j = 0; j < PW[s]; j++) p = {p[14:0], bitq.pop_front()};
      exp_q.push_back({l && (bitq.size() == 0), p});
    end
    if (l && bitq.size() != 0) begin
      p = 16'd0;
      n = bitq.size();
      for (int j = 0; j < PW[s]; j++) p = {p[14:0], (j < n) ? bitq.pop_front() : 1'b0};
      exp_q.push_back({1'b1, p});
    end
  endtask

  // Compare process: check handed-over packets, hold stability and fill bounds each cycle.
  always @(negedge clk) begin : cmp
    int s;
    s = sel;
    if (rst) begin
      exp_q.delete();
      bitq.delete();
      held_v = 1'b0;
    end else begin
      check("fill_bound", {63'd0, fl_a[s] <= ACCW[s]}, 64'd1);
      if (held_v) begin
        check("hold_valid", {63'd0, ov_a[s]}, 64'd1);
        check("hold_data", {48'd0, od_a[s]}, {48'd0, held_d});
        check("hold_last", {63'd0, ol_a[s]}, {63'd0, held_l});
      end
      if (ov_a[s]) begin
        if (exp_q.size() == 0) begin
          check("spurious_valid", {63'd0, ov_a[s]}, 64'd0);
        end else begin
          check("pkt_data", {48'd0, od_a[s]}, {48'd0, exp_q[0][15:0]});
          check("pkt_last", {63'd0, ol_a[s]}, {63'd0, exp_q[0][16]});
          if (or_s[s]) begin
            void'(exp_q.pop_front());
            got_q.push_back({ol_a[s], od_a[s]});
          end
        end
      end
      held_v = ov_a[s] && !or_s[s];
      held_d = od_a[s];
      held_l = ol_a[s];
      if (iv_s[s] && ir_a[s]) model_push(in_data_g, in_last_g, s);
    end
  end

  task automatic do_reset(input int s);
    rst = 1'b1;
    sel = s;
    in_valid_g = 1'b0;
    in_last_g = 1'b0;
    dir_rdy = 1'b0;
    rand_mode = 1'b0;
    @(negedge clk);
    check("rst_in_ready", {63'd0, ir_a[s]}, 64'd0);
    check("rst_out_valid", {63'd0, ov_a[s]}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rel_in_ready", {63'd0, ir_a[s]}, 64'd1);
    check("rel_out_valid", {63'd0, ov_a[s]}, 64'd0);
    check("rel_fill", {56'd0, fl_a[s]}, 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic push_word(input logic [63:0] d, input logic l);
    int n = 0;
    in_valid_g = 1'b1;
    in_data_g = d;
    in_last_g = l;
    @(negedge clk);
    while (!ir_a[sel] && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) check("push_timeout", {63'd0, ir_a[sel]}, 64'd1);
    @(posedge clk); #1;
    in_valid_g = 1'b0;
    in_last_g = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    logic done = 1'b0;
    while (!done && n < 3000) begin
      @(negedge clk);
      done = (exp_q.size() == 0) && !ov_a[sel];
      n++;
    end
    check("drain_done", {63'd0, done}, 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic random_frames(input int words);
    rand_mode = 1'b1;
    for (int k = 0; k < words; k++) begin
      push_word({$urandom, $urandom}, (k == words - 1) || ($urandom_range(0, 3) == 0));
    end
    wait_drain();
    rand_mode = 1'b0;
  endtask

  logic [15:0] lit9 [9] = '{16'h09, 16'h0D, 16'h0A, 16'h67, 16'h44, 16'h6A, 16'h79, 16'h5E, 16'h78};
  logic [15:0] litf [5] = '{16'h7F, 16'h7F, 16'h7F, 16'h7F, 16'h78};

  task automatic check_ff_frame(input int b);
    check("ff_count", 64'(got_q.size() - b), 64'd5);
    for (int k = 0; k < 5; k++) begin
      if (b + k < got_q.size()) begin
        check("ff_data", {48'd0, got_q[b+k][15:0]}, {48'd0, litf[k]});
        check("ff_last", {63'd0, got_q[b+k][16]}, (k == 4) ? 64'd1 : 64'd0);
      end
    end
  endtask

  initial begin
    int b;
    int lasts;

    // Reset defaults, then two words with no backpressure and no last.
    do_reset(0);
    dir_rdy = 1'b1;
    b = got_q.size();
    push_word(64'h1234_5678, 1'b0);
    push_word(64'h9ABC_DEF0, 1'b0);
    wait_drain();
    check("run_count", 64'(got_q.size() - b), 64'd9);
    for (int k = 0; k < 9; k++) begin
      if (b + k < got_q.size()) begin
        check("run_data", {48'd0, got_q[b+k][15:0]}, {48'd0, lit9[k]});
        check("run_last", {63'd0, got_q[b+k][16]}, 64'd0);
      end
    end
    @(negedge clk);
    check("run_fill", {56'd0, fl_a[0]}, 64'd1);
    @(posedge clk); #1;

    // Single-word frame: four full packets, then a padded last one.
    do_reset(0);
    dir_rdy = 1'b1;
    b = got_q.size();
    push_word(64'hFFFF_FFFF, 1'b1);
    @(negedge clk);
    check("latency_valid", {63'd0, ov_a[0]}, 64'd1);
    check("drain_in_ready", {63'd0, ir_a[0]}, 64'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("drain_in_ready", {63'd0, ir_a[0]}, 64'd0);
    end
    @(negedge clk);
    check("after_drain_ready", {63'd0, ir_a[0]}, 64'd1);
    @(posedge clk); #1;
    wait_drain();
    check_ff_frame(b);

    // Exact-fit frame: 224 bits give 32 packets with no padding packet.
    do_reset(0);
    dir_rdy = 1'b1;
    b = got_q.size();
    for (int k = 0; k < 7; k++) push_word(64'(32'hA5C3_0F01 + 32'(k) * 32'h1357_9BDF), k == 6);
    wait_drain();
    check("fit_count", 64'(got_q.size() - b), 64'd32);
    lasts = 0;
    for (int k = b; k < got_q.size(); k++) lasts += int'(got_q[k][16]);
    check("fit_last_count", 64'(lasts), 64'd1);
    if (got_q.size() >= b + 32) check("fit_last_pos", {63'd0, got_q[b+31][16]}, 64'd1);

    // Random backpressure against the scoreboard.
    do_reset(0);
    random_frames(20);

    // Reset in DRAIN with fill=20: four words leave a 2-bit residue,
    // a last word makes 34, and two pops bring it to 20.
    do_reset(0);
    dir_rdy = 1'b1;
    for (int k = 0; k < 4; k++) push_word(64'(32'h0BAD_F00D ^ (32'(k) << 8)), 1'b0);
    wait_drain();
    @(negedge clk);
    check("res_fill", {56'd0, fl_a[0]}, 64'd2);
    @(posedge clk); #1;
    dir_rdy = 1'b0;
    push_word(64'hCAFE_F00D, 1'b1);
    dir_rdy = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    dir_rdy = 1'b0;
    @(negedge clk);
    check("mid_fill", {56'd0, fl_a[0]}, 64'd20);
    check("mid_in_ready", {63'd0, ir_a[0]}, 64'd0);
    #1 rst = 1'b1;
    @(negedge clk);
    check("mid_rst_valid", {63'd0, ov_a[0]}, 64'd0);
    check("mid_rst_fill", {56'd0, fl_a[0]}, 64'd0);
    check("mid_rst_ready", {63'd0, ir_a[0]}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rel_ready", {63'd0, ir_a[0]}, 64'd1);
    @(posedge clk); #1;
    dir_rdy = 1'b1;
    b = got_q.size();
    push_word(64'hFFFF_FFFF, 1'b1);
    wait_drain();
    check_ff_frame(b);

    // (16,16): packet equals word; last rides the exact-fit packet.
    do_reset(1);
    dir_rdy = 1'b1;
    b = got_q.size();
    push_word(64'h1234, 1'b0);
    push_word(64'hABCD, 1'b1);
    wait_drain();
    check("w16_count", 64'(got_q.size() - b), 64'd2);
    if (got_q.size() >= b + 2) begin
      check("w16_p0", {47'd0, got_q[b]}, {47'd0, 17'h0_1234});
      check("w16_p1", {47'd0, got_q[b+1]}, {47'd0, 17'h1_ABCD});
    end
    random_frames(10);

    // (8,3): 0xB4 = 101 101 00 -> 5, 5, 0 padded and last.
    do_reset(2);
    dir_rdy = 1'b1;
    b = got_q.size();
    push_word(64'hB4, 1'b1);
    wait_drain();
    check("w8_count", 64'(got_q.size() - b), 64'd3);
    if (got_q.size() >= b + 3) begin
      check("w8_p0", {47'd0, got_q[b]}, {47'd0, 17'h0_0005});
      check("w8_p1", {47'd0, got_q[b+1]}, {47'd0, 17'h0_0005});
      check("w8_p2", {47'd0, got_q[b+2]}, {47'd0, 17'h1_0000});
    end
    random_frames(10);

    // (64,1): one bit per packet.
    do_reset(3);
    dir_rdy = 1'b1;
    b = got_q.size();
    push_word(64'h8000_0000_0000_0001, 1'b1);
    wait_drain();
    check("w64_count", 64'(got_q.size() - b), 64'd64);
    if (got_q.size() >= b + 64) begin
      check("w64_first", {47'd0, got_q[b]}, {47'd0, 17'h0_0001});
      check("w64_second", {47'd0, got_q[b+1]}, {47'd0, 17'h0_0000});
      check("w64_final", {47'd0, got_q[b+63]}, {47'd0, 17'h1_0001});
    end
    random_frames(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
